// File: rtl/mixer_pkg.sv
// ============================================================================
// Module      : mixer_pkg
// Description : Shared register map, envelope modes and FSM encodings.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mixer_pkg;

    localparam logic [2:0] c_addr_vol      = 3'd0;
    localparam logic [2:0] c_addr_ctl      = 3'd1;
    localparam logic [2:0] c_addr_rate_a   = 3'd2;
    localparam logic [2:0] c_addr_rate_b   = 3'd3;
    localparam logic [2:0] c_addr_mode_a   = 3'd4;
    localparam logic [2:0] c_addr_mode_b   = 3'd5;
    localparam logic [2:0] c_addr_commit   = 3'd6;

    localparam logic [1:0] c_mode_const    = 2'b00;
    localparam logic [1:0] c_mode_decay    = 2'b01;
    localparam logic [1:0] c_mode_attack   = 2'b10;
    localparam logic [1:0] c_mode_repeat   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_APPLY   = 2'd2
    } ctrl_state_t;

    typedef enum logic [1:0] {
        ENV_HOLD   = 2'd0,
        ENV_ATTACK = 2'd1,
        ENV_DECAY  = 2'd2
    } env_state_t;

    function automatic logic [3:0] env_start_level(input logic [1:0] mode);
        return (mode == c_mode_attack) ? 4'h0 : 4'hF;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mixer_env.sv
// ============================================================================
// Module      : mixer_env
// Description : Single-channel envelope generator with tick-divided stepping.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mixer_env
    import mixer_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       retrig,
    input  logic [7:0] rate_in,
    input  logic [1:0] mode_in,
    output logic [3:0] level
);

    env_state_t state_q, state_d;
    logic [3:0] level_q, level_d;
    logic [7:0] div_q,   div_d;
    logic [7:0] rate_q,  rate_d;
    logic [1:0] mode_q,  mode_d;

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        div_d   = div_q;
        rate_d  = rate_q;
        mode_d  = mode_q;

        if (retrig) begin
            rate_d  = rate_in;
            mode_d  = mode_in;
            div_d   = 8'd0;
            level_d = env_start_level(mode_in);
            case (mode_in)
                c_mode_const:  state_d = ENV_HOLD;
                c_mode_attack: state_d = ENV_ATTACK;
                default:       state_d = ENV_DECAY;
            endcase
        end else if (tick && (state_q != ENV_HOLD)) begin
            if (div_q == rate_q) begin
                div_d = 8'd0;
                if (state_q == ENV_ATTACK) begin
                    if (level_q != 4'hF) begin
                        level_d = level_q + 4'd1;
                    end
                    if (level_q >= 4'hE) begin
                        state_d = ENV_HOLD;
                    end
                end else if (level_q == 4'h0) begin
                    // Repeating decay sits at zero for one period before reloading.
                    if (mode_q == c_mode_repeat) begin
                        level_d = 4'hF;
                    end else begin
                        state_d = ENV_HOLD;
                    end
                end else begin
                    level_d = level_q - 4'd1;
                    if ((level_q == 4'h1) && (mode_q != c_mode_repeat)) begin
                        state_d = ENV_HOLD;
                    end
                end
            end else begin
                div_d = div_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ENV_HOLD;
            level_q <= 4'hF;
            div_q   <= 8'd0;
            rate_q  <= 8'd0;
            mode_q  <= c_mode_const;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            div_q   <= div_d;
            rate_q  <= rate_d;
            mode_q  <= mode_d;
        end
    end

    assign level = level_q;

endmodule

`default_nettype wire

// File: rtl/mixer_ctrl.sv
// ============================================================================
// Module      : mixer_ctrl
// Description : Shadowed mixer register file committed on the sample tick.
//               Envelope generators built only with MIXER_CTRL_ENV_EN defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mixer_ctrl
    import mixer_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [2:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       tick,
    output logic [3:0] volumeA,
    output logic [3:0] volumeB,
    output logic [3:0] volumeNoise,
    output logic [3:0] envA,
    output logic [3:0] envB,
    output logic       enableA,
    output logic       enableB,
    output logic       enableNoise
);

    ctrl_state_t state_q, state_d;
    logic        wr_ready_q, wr_ready_d;
    logic        wr_fire;

    logic [3:0] sh_vol_a_q, sh_vol_a_d;
    logic [3:0] sh_vol_b_q, sh_vol_b_d;
    logic [3:0] sh_vol_n_q, sh_vol_n_d;
    logic       sh_en_a_q,  sh_en_a_d;
    logic       sh_en_b_q,  sh_en_b_d;
    logic       sh_en_n_q,  sh_en_n_d;

    logic [3:0] vol_a_q, vol_a_d;
    logic [3:0] vol_b_q, vol_b_d;
    logic [3:0] vol_n_q, vol_n_d;
    logic       en_a_q,  en_a_d;
    logic       en_b_q,  en_b_d;
    logic       en_n_q,  en_n_d;

    assign wr_fire = wr_valid && wr_ready_q;

    always_comb begin
        state_d    = state_q;
        sh_vol_a_d = sh_vol_a_q;
        sh_vol_b_d = sh_vol_b_q;
        sh_vol_n_d = sh_vol_n_q;
        sh_en_a_d  = sh_en_a_q;
        sh_en_b_d  = sh_en_b_q;
        sh_en_n_d  = sh_en_n_q;
        vol_a_d    = vol_a_q;
        vol_b_d    = vol_b_q;
        vol_n_d    = vol_n_q;
        en_a_d     = en_a_q;
        en_b_d     = en_b_q;
        en_n_d     = en_n_q;

        // A tick on the commit edge is seen while still IDLE, so it never applies.
        case (state_q)
            ST_IDLE: begin
                if (wr_fire && (wr_addr == c_addr_commit)) begin
                    state_d = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (tick) begin
                    state_d = ST_APPLY;
                end
            end
            ST_APPLY: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        wr_ready_d = (state_d == ST_IDLE);

        if (wr_fire) begin
            case (wr_addr)
                c_addr_vol: begin
                    sh_vol_b_d = wr_data[7:4];
                    sh_vol_a_d = wr_data[3:0];
                end
                c_addr_ctl: begin
                    sh_en_n_d  = wr_data[6];
                    sh_en_b_d  = wr_data[5];
                    sh_en_a_d  = wr_data[4];
                    sh_vol_n_d = wr_data[3:0];
                end
                default: ;
            endcase
        end

        if (state_q == ST_APPLY) begin
            vol_a_d = sh_vol_a_q;
            vol_b_d = sh_vol_b_q;
            vol_n_d = sh_vol_n_q;
            en_a_d  = sh_en_a_q;
            en_b_d  = sh_en_b_q;
            en_n_d  = sh_en_n_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wr_ready_q <= 1'b1;
            sh_vol_a_q <= 4'h0;
            sh_vol_b_q <= 4'h0;
            sh_vol_n_q <= 4'h0;
            sh_en_a_q  <= 1'b0;
            sh_en_b_q  <= 1'b0;
            sh_en_n_q  <= 1'b0;
            vol_a_q    <= 4'h0;
            vol_b_q    <= 4'h0;
            vol_n_q    <= 4'h0;
            en_a_q     <= 1'b0;
            en_b_q     <= 1'b0;
            en_n_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ready_q <= wr_ready_d;
            sh_vol_a_q <= sh_vol_a_d;
            sh_vol_b_q <= sh_vol_b_d;
            sh_vol_n_q <= sh_vol_n_d;
            sh_en_a_q  <= sh_en_a_d;
            sh_en_b_q  <= sh_en_b_d;
            sh_en_n_q  <= sh_en_n_d;
            vol_a_q    <= vol_a_d;
            vol_b_q    <= vol_b_d;
            vol_n_q    <= vol_n_d;
            en_a_q     <= en_a_d;
            en_b_q     <= en_b_d;
            en_n_q     <= en_n_d;
        end
    end

`ifdef MIXER_CTRL_ENV_EN
    logic [7:0] sh_rate_a_q, sh_rate_a_d;
    logic [7:0] sh_rate_b_q, sh_rate_b_d;
    logic [1:0] sh_mode_a_q, sh_mode_a_d;
    logic [1:0] sh_mode_b_q, sh_mode_b_d;
    logic       env_tick;
    logic       env_retrig;

    always_comb begin
        sh_rate_a_d = sh_rate_a_q;
        sh_rate_b_d = sh_rate_b_q;
        sh_mode_a_d = sh_mode_a_q;
        sh_mode_b_d = sh_mode_b_q;
        if (wr_fire) begin
            case (wr_addr)
                c_addr_rate_a: sh_rate_a_d = wr_data;
                c_addr_rate_b: sh_rate_b_d = wr_data;
                c_addr_mode_a: sh_mode_a_d = wr_data[1:0];
                c_addr_mode_b: sh_mode_b_d = wr_data[1:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh_rate_a_q <= 8'd0;
            sh_rate_b_q <= 8'd0;
            sh_mode_a_q <= c_mode_const;
            sh_mode_b_q <= c_mode_const;
        end else begin
            sh_rate_a_q <= sh_rate_a_d;
            sh_rate_b_q <= sh_rate_b_d;
            sh_mode_a_q <= sh_mode_a_d;
            sh_mode_b_q <= sh_mode_b_d;
        end
    end

    // The tick that moves PENDING->APPLY and the APPLY cycle never step envelopes.
    assign env_tick   = tick && (state_q == ST_IDLE);
    assign env_retrig = (state_q == ST_APPLY);

    mixer_env u_env_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .tick    (env_tick),
        .retrig  (env_retrig),
        .rate_in (sh_rate_a_q),
        .mode_in (sh_mode_a_q),
        .level   (envA)
    );

    mixer_env u_env_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .tick    (env_tick),
        .retrig  (env_retrig),
        .rate_in (sh_rate_b_q),
        .mode_in (sh_mode_b_q),
        .level   (envB)
    );
`else
    logic w_unused;
    assign w_unused = wr_data[7];
    assign envA     = 4'hF;
    assign envB     = 4'hF;
`endif

    assign wr_ready    = wr_ready_q;
    assign volumeA     = vol_a_q;
    assign volumeB     = vol_b_q;
    assign volumeNoise = vol_n_q;
    assign enableA     = en_a_q;
    assign enableB     = en_b_q;
    assign enableNoise = en_n_q;

endmodule

`default_nettype wire
